simd_functional_unit: RTL and testbench

- Parametrised, multi-lane successor to the single-lane HARP execute ALU.
- Executes one warp instruction at a time across LANES thread lanes, with a per-lane active mask.
- Uses a valid/ready handshake on input and output, a registered output stage, and a multi-cycle iterative divider for div/mod.
- Sits in the Execute stage between operand fetch and writeback.

---
 rtl/harp_fu_pkg.sv | 34 +++
 rtl/fu_div_lane.sv | 59 +++++
 rtl/simd_functional_unit.sv | 200 ++++++++++++++++++++
 tb/tb_simd_functional_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harp_fu_pkg.sv
// Shared types and helpers for the multi-lane HARP execute unit.
package harp_fu_pkg;

    // HARP ALU opcode encoding; 0x0F-0x1F are unused and produce zero.
    typedef enum logic [4:0] {
        OP_NOP    = 5'h00,
        OP_NEG    = 5'h01,
        OP_NOT    = 5'h02,
        OP_AND    = 5'h03,
        OP_OR     = 5'h04,
        OP_XOR    = 5'h05,
        OP_ADD    = 5'h06,
        OP_SUB    = 5'h07,
        OP_MUL    = 5'h08,
        OP_DIV    = 5'h09,
        OP_MOD    = 5'h0A,
        OP_SHL    = 5'h0B,
        OP_SHR    = 5'h0C,
        OP_ISNEG  = 5'h0D,
        OP_ISZERO = 5'h0E
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StDrain
    } fu_state_e;

    // Ops that go through the iterative divider instead of the single-cycle path.
    function automatic logic is_multicycle(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/fu_div_lane.sv
// One lane of the restoring divider: one quotient bit per step, MSB first.
module fu_div_lane #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;
    logic             r_div0;

    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_rem_nxt;

    // Trial subtraction for the current step. A zero divisor always "fits", which
    // naturally yields an all-ones quotient and shifts the dividend into the remainder.
    always_comb begin
        w_trial   = {r_rem, r_quo[WIDTH-1]};
        w_ge      = (w_trial >= {1'b0, r_dsr});
        // When the trial fits, the true difference is below the divisor, so WIDTH bits suffice.
        w_rem_nxt = w_ge ? (w_trial[WIDTH-1:0] - r_dsr) : w_trial[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    end

    // Operand latch on start, one division step per cycle while step is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_dsr  <= '0;
            r_div0 <= 1'b0;
        end else if (start) begin
            r_quo  <= dividend;
            r_rem  <= '0;
            r_dsr  <= divisor;
            r_div0 <= (divisor == '0);
        end else if (step) begin
            r_quo  <= w_quo_nxt;
            r_rem  <= w_rem_nxt;
        end
    end

    // Post-step view so the top can capture the final step on the same edge it happens.
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;
    assign div0      = r_div0;

endmodule

// File: rtl/simd_functional_unit.sv
// Multi-lane execute unit: single-cycle ALU ops plus an iterative div/mod path.
module simd_functional_unit
    import harp_fu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_op,
    input  logic [LANES-1:0]       in_mask,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic [LANES-1:0]       out_mask,
    output logic [TAG_W-1:0]       out_tag,
    output logic [LANES-1:0]       out_div0
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WidthV = WIDTH'(WIDTH);

    fu_state_e        r_state;
    fu_state_e        w_state_d;
    logic [CntW-1:0]  r_count;
    logic [CntW-1:0]  w_count_d;
    logic             w_div_done;

    logic             w_accept;
    logic             w_start;
    logic             w_step;

    logic [LANES-1:0] r_div_mask;
    logic [TAG_W-1:0] r_div_tag;
    logic             r_div_is_mod;

    logic                   r_out_valid;
    logic [LANES*WIDTH-1:0] r_out_result;
    logic [LANES-1:0]       r_out_mask;
    logic [TAG_W-1:0]       r_out_tag;
    logic [LANES-1:0]       r_out_div0;

    logic [LANES*WIDTH-1:0] w_alu_res;
    logic [LANES*WIDTH-1:0] w_div_res;
    logic [LANES-1:0]       w_div_div0;

    assign in_ready = (r_state == StIdle) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_start  = w_accept && is_multicycle(in_op);
    assign w_step   = (r_state == StDiv);

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_alu;
        logic [WIDTH-1:0] w_quo;
        logic [WIDTH-1:0] w_rem;
        logic             w_div0;

        assign w_a = in_a[g*WIDTH +: WIDTH];
        assign w_b = in_b[g*WIDTH +: WIDTH];

        // Single-cycle lane result; inactive lanes and unused opcodes give zero.
        always_comb begin
            w_alu = '0;
            case (in_op)
                OP_NEG:    w_alu = -w_a;
                OP_NOT:    w_alu = ~w_a;
                OP_AND:    w_alu = w_a & w_b;
                OP_OR:     w_alu = w_a | w_b;
                OP_XOR:    w_alu = w_a ^ w_b;
                OP_ADD:    w_alu = w_a + w_b;
                OP_SUB:    w_alu = w_a - w_b;
                OP_MUL:    w_alu = w_a * w_b;
                OP_SHL:    w_alu = (w_b < WidthV) ? (w_a << w_b) : '0;
                OP_SHR:    w_alu = (w_b < WidthV) ? (w_a >> w_b) : '0;
                OP_ISNEG:  w_alu = {{(WIDTH-1){1'b0}}, w_a[WIDTH-1]};
                OP_ISZERO: w_alu = {{(WIDTH-1){1'b0}}, (w_a == '0)};
                default:   w_alu = '0;
            endcase
            if (!in_mask[g]) begin
                w_alu = '0;
            end
        end

        fu_div_lane #(
            .WIDTH(WIDTH)
        ) u_div_lane (
            .clk      (clk),
            .reset    (reset),
            .start    (w_start),
            .step     (w_step),
            .dividend (w_a),
            .divisor  (w_b),
            .quotient (w_quo),
            .remainder(w_rem),
            .div0     (w_div0)
        );

        assign w_alu_res[g*WIDTH +: WIDTH] = w_alu;
        assign w_div_res[g*WIDTH +: WIDTH] =
            r_div_mask[g] ? (r_div_is_mod ? w_rem : w_quo) : '0;
        assign w_div_div0[g] = r_div_mask[g] & w_div0;
    end

    // FSM state and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
        end
    end

    // Next-state: IDLE -> DIV on div/mod accept, DIV for WIDTH steps, DRAIN until taken.
    always_comb begin
        w_state_d  = r_state;
        w_count_d  = r_count;
        w_div_done = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StDiv;
                    w_count_d = '0;
                end
            end
            StDiv: begin
                w_count_d = r_count + 1'b1;
                if (r_count == LastCnt) begin
                    w_div_done = 1'b1;
                    w_state_d  = StDrain;
                end
            end
            StDrain: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Mask/tag/op kind of the instruction occupying the divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_mask   <= '0;
            r_div_tag    <= '0;
            r_div_is_mod <= 1'b0;
        end else if (w_start) begin
            r_div_mask   <= in_mask;
            r_div_tag    <= in_tag;
            r_div_is_mod <= (in_op == OP_MOD);
        end
    end

    // Output register: cleared on transfer, loaded by a single-cycle accept or divider finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_mask   <= '0;
            r_out_tag    <= '0;
            r_out_div0   <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !is_multicycle(in_op)) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_alu_res;
                r_out_mask   <= in_mask;
                r_out_tag    <= in_tag;
                r_out_div0   <= '0;
            end else if (w_div_done) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_div_res;
                r_out_mask   <= r_div_mask;
                r_out_tag    <= r_div_tag;
                r_out_div0   <= w_div_div0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_mask   = r_out_mask;
    assign out_tag    = r_out_tag;
    assign out_div0   = r_out_div0;

endmodule

// File: tb/tb_simd_functional_unit.sv
// Directed self-checking bench for simd_functional_unit (WIDTH=32, LANES=4, TAG_W=4).
module tb_simd_functional_unit;
    import harp_fu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_op;
    logic [3:0]   in_mask;
    logic [127:0] in_a;
    logic [127:0] in_b;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_result;
    logic [3:0]   out_mask;
    logic [3:0]   out_tag;
    logic [3:0]   out_div0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]   op;
        logic [3:0]   mask;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] exp;
    } vec_t;

    simd_functional_unit #(
        .WIDTH(32),
        .LANES(4),
        .TAG_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_mask   (in_mask),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_mask  (out_mask),
        .out_tag   (out_tag),
        .out_div0  (out_div0)
    );

    always #5 clk = ~clk;

    // Lane 0 is listed first.
    function automatic logic [127:0] pk(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Offer one instruction and return #1 after its accept edge with in_valid low.
    task automatic send(input logic [4:0] op, input logic [3:0] mask, input logic [127:0] a,
                        input logic [127:0] b, input logic [3:0] tag);
        int guard = 0;
        in_op    = op;
        in_mask  = mask;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Let any pending result drain with out_ready high.
    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op     = '0;
        in_mask   = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        n_checks++;
        if (out_result !== 128'd0) begin
            n_errors++; $display("FAIL reset_out_result: got %h required 0", out_result);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        n_checks++;
        if (out_tag !== 4'd0 || out_mask !== 4'd0 || out_div0 !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_side: tag=%h mask=%b div0=%b required 0/0000/0000",
                     out_tag, out_mask, out_div0);
        end
    endtask

    // Back-to-back single-cycle ops with out_ready high: one result per cycle.
    task automatic test_single_cycle();
        vec_t v[9];
        v[0] = '{OP_ADD, 4'hF, pk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                 pk(1, 1, 1, 1), pk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000)};
        v[1] = '{OP_SUB, 4'hF, pk(0, 0, 0, 0), pk(1, 1, 1, 1),
                 pk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF)};
        v[2] = '{OP_ISNEG, 4'hF, pk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
                 pk(0, 0, 0, 0), pk(1, 1, 1, 1)};
        v[3] = '{OP_ISNEG, 4'hF, pk(32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 0),
                 pk(0, 0, 0, 0), pk(1, 0, 1, 0)};
        v[4] = '{OP_ISZERO, 4'hF, pk(0, 1, 32'h80000000, 0), pk(0, 0, 0, 0), pk(1, 0, 0, 1)};
        v[5] = '{OP_MUL, 4'hF, pk(3, 32'h10000, 32'hFFFFFFFF, 12345), pk(5, 32'h10000, 2, 0),
                 pk(15, 0, 32'hFFFFFFFE, 0)};
        v[6] = '{OP_NEG, 4'hF, pk(1, 0, 5, 32'h80000000), pk(0, 0, 0, 0),
                 pk(32'hFFFFFFFF, 0, 32'hFFFFFFFB, 32'h80000000)};
        v[7] = '{5'h1F, 4'hF, pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(0, 0, 0, 0)};
        v[8] = '{OP_ADD, 4'h0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(0, 0, 0, 0)};
        idle();
        for (int i = 0; i < 9; i++) begin
            send(v[i].op, v[i].mask, v[i].a, v[i].b, 4'(i));
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== v[i].exp || out_mask !== v[i].mask ||
                out_tag !== 4'(i) || out_div0 !== 4'd0) begin
                n_errors++;
                $display("FAIL single_%0d: valid=%0b res=%h mask=%b tag=%h div0=%b required 1 %h %b %h 0000",
                         i, out_valid, out_result, out_mask, out_tag, out_div0,
                         v[i].exp, v[i].mask, 4'(i));
            end
        end
    endtask

    task automatic test_mask_shift();
        vec_t v[2];
        v[0] = '{OP_SHL, 4'b1011, pk(1, 1, 1, 1), pk(3, 31, 32, 40),
                 pk(32'h8, 32'h80000000, 0, 0)};
        v[1] = '{OP_SHR, 4'b1111, pk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
                 pk(0, 31, 32, 1), pk(32'h80000000, 1, 0, 32'h40000000)};
        idle();
        for (int i = 0; i < 2; i++) begin
            send(v[i].op, v[i].mask, v[i].a, v[i].b, 4'(i + 8));
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== v[i].exp || out_mask !== v[i].mask) begin
                n_errors++;
                $display("FAIL shift_%0d: valid=%0b res=%h mask=%b required 1 %h %b",
                         i, out_valid, out_result, out_mask, v[i].exp, v[i].mask);
            end
        end
    endtask

    // Div then mod; the div result is held in DRAIN for two cycles before being taken.
    task automatic test_div();
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] exp [2];
        logic [4:0]   ops [2];
        int           n;
        a      = pk(100, 7, 32'hFFFFFFFF, 5);
        b      = pk(7, 0, 1, 5);
        exp[0] = pk(14, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        exp[1] = pk(2, 7, 0, 0);
        ops[0] = OP_DIV;
        ops[1] = OP_MOD;
        for (int k = 0; k < 2; k++) begin
            idle();
            out_ready = (k == 1);
            send(ops[k], 4'hF, a, b, 4'(7 + k));
            n = 1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_errors++; $display("FAIL div_busy_%0d: in_ready=%0b required 0", k, in_ready);
            end
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            n_checks++;
            if (n != 33) begin
                n_errors++; $display("FAIL div_latency_%0d: got %0d cycles required 33", k, n);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== exp[k] || out_div0 !== 4'b0010 ||
                out_tag !== 4'(7 + k) || out_mask !== 4'hF) begin
                n_errors++;
                $display("FAIL div_result_%0d: valid=%0b res=%h div0=%b tag=%h mask=%b required 1 %h 0010 %h 1111",
                         k, out_valid, out_result, out_div0, out_tag, out_mask, exp[k], 4'(7 + k));
            end
            if (k == 0) begin
                repeat (2) @(posedge clk);
                #1;
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== exp[0]) begin
                    n_errors++;
                    $display("FAIL div_drain_hold: valid=%0b in_ready=%0b res=%h required 1 0 %h",
                             out_valid, in_ready, out_result, exp[0]);
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                n_checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL div_drain_release: valid=%0b in_ready=%0b required 0 1",
                             out_valid, in_ready);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp5;
        logic [127:0] exp6;
        exp5 = pk(11, 22, 33, 44);
        exp6 = pk(6, 7, 8, 9);
        idle();
        out_ready = 1'b0;
        send(OP_ADD, 4'hF, pk(1, 2, 3, 4), pk(10, 20, 30, 40), 4'd5);
        in_op    = OP_ADD;
        in_mask  = 4'hF;
        in_a     = pk(5, 5, 5, 5);
        in_b     = pk(1, 2, 3, 4);
        in_tag   = 4'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== exp5 || out_tag !== 4'd5 ||
                in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold_%0d: valid=%0b res=%h tag=%h in_ready=%0b required 1 %h 5 0",
                         i, out_valid, out_result, out_tag, in_ready, exp5);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_tag !== 4'd5) begin
            n_errors++;
            $display("FAIL bp_same_cycle: in_ready=%0b tag=%h required 1 5", in_ready, out_tag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd6 || out_result !== exp6) begin
            n_errors++;
            $display("FAIL bp_next_beat: valid=%0b tag=%h res=%h required 1 6 %h",
                     out_valid, out_tag, out_result, exp6);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_no_dup: valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        int seen = 0;
        idle();
        send(OP_DIV, 4'hF, pk(100, 7, 32'hFFFFFFFF, 5), pk(7, 0, 1, 5), 4'd9);
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_div_idle: in_ready=%0b valid=%0b required 1 0", in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++; $display("FAIL rst_div_no_output: got %0d valid cycles required 0", seen);
        end
        send(OP_ADD, 4'hF, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 4'hA);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== pk(2, 3, 4, 5) || out_tag !== 4'hA ||
            out_div0 !== 4'd0) begin
            n_errors++;
            $display("FAIL rst_div_add: valid=%0b res=%h tag=%h div0=%b required 1 %h a 0000",
                     out_valid, out_result, out_tag, out_div0, pk(2, 3, 4, 5));
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mask_shift();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
